popcount_seq: RTL and testbench
===============================

Name: popcount_seq

Overview:
- Sequential, parametrised successor to the team's 3-input ones-counter (the 2-bit y = number of set inputs among a, b, c).
- Accepts a WIDTH-bit word over a valid/ready handshake and counts its set bits serially, STEP bits per clock.
- Returns the count over a second valid/ready handshake.
- Sits between a data source and the display/result logic in the lab datapath. Area is traded for latency through STEP.

Parameters:
- WIDTH, 8, input word width; must be >= 1.
- STEP, 1, bits consumed per COUNT cycle; must divide WIDTH exactly (elaboration-time $error otherwise).
- CW (localparam), $clog2(WIDTH+1), count width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  source presents in_data
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  word to count
- out_valid  output  1  out_count is valid
- out_ready  input  1  sink accepts result
- out_count  output  CW  number of 1 bits in the accepted word
- busy  output  1  high in COUNT or DONE

Behaviour:
- Interface decision: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, takes effect immediately):
  - state=IDLE
  - in_ready=1, out_valid=0, out_count=0, busy=0
  - shift register, accumulator and beat counter all cleared
- States: IDLE, COUNT, DONE. Encoding is free.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge k: shift<=in_data, acc<=0, beats<=WIDTH/STEP, go to COUNT.
- COUNT:
  - in_ready=0, busy=1.
  - Each cycle: acc <= acc + popcount(shift[STEP-1:0]); shift <= shift >> STEP; beats <= beats-1.
  - On the cycle where beats==1, go to DONE and latch out_count <= final sum.
- DONE:
  - out_valid=1, in_ready=0, busy=1.
  - Hold out_count stable until out_valid && out_ready.
  - On that edge: out_valid<=0, go to IDLE.
- Latency: word accepted at edge k gives out_valid=1 after edge k+WIDTH/STEP.
  - Example: WIDTH=8, STEP=1 gives 8 cycles.
- Throughput: one word per WIDTH/STEP+2 cycles at best, since IDLE is always spent between words.
- No back-to-back accept: in_ready is 0 in DONE even when out_ready=1 in the same cycle.
- Width rules:
  - Accumulator is CW bits and cannot overflow, since the maximum value is WIDTH.
  - The per-beat popcount is zero-extended to CW before the add.
- out_count keeps its last value in IDLE. It is only meaningful while out_valid=1.
- in_data is ignored outside the accepting edge. Changing in_data during COUNT has no effect.
- out_ready asserted in IDLE or COUNT is ignored.
- Reset asserted mid-COUNT or mid-DONE: the word is discarded, all outputs return to reset values, and no result is emitted.
- Boundaries:
  - All-zeros word gives 0.
  - All-ones word gives WIDTH, so out_count MSB is set when WIDTH is a power of 2.
  - WIDTH==STEP gives a single COUNT cycle.

Optional Feature:
- Macro: POPCOUNT_SEQ_ABORT_EN.
- When defined:
  - Adds input port `abort` (1 bit, synchronous).
  - abort=1 at a rising edge in COUNT or DONE forces IDLE. out_valid<=0, acc<=0, out_count unchanged, and no result is delivered.
  - abort in IDLE is ignored and takes priority over nothing else. If abort and in_valid are both high in IDLE, the word is accepted.
- When undefined: no abort port, and behaviour is exactly as above.

Test Plan:
1. WIDTH=8, STEP=1. Reset, then in_data=8'hA5 with in_valid=1 for one cycle -> in_ready drops the next cycle; out_valid=1 exactly 8 edges after accept with out_count=4; busy=1 throughout.
2. WIDTH=8. Send 8'h00, then 8'hFF -> out_count=0 then 8 (4'b1000). in_ready stays 0 during DONE, and the second word is accepted only after returning to IDLE.
3. Backpressure: result 3 from 8'h0B with out_ready held 0 for 5 cycles -> out_valid=1 and out_count=3 stable all 5 cycles; IDLE on the edge where out_ready=1.
4. Reset mid-operation: accept 8'hFF, drop rst_n asynchronously (between edges) after 3 cycles -> out_valid=0, busy=0, in_ready=1, out_count=0 immediately; no out_valid pulse after release.
5. WIDTH=16, STEP=4. Send 16'hFFFF, then 16'h8001 -> out_count=16 then 2, each with out_valid 4 edges after accept.
6. With POPCOUNT_SEQ_ABORT_EN defined: accept 8'hFF, abort=1 on the 2nd COUNT cycle -> IDLE the next cycle; no out_valid; a following 8'h01 yields 1.

Source files
------------

// File: rtl/popcount_seq.sv
// Serial popcount: accepts a WIDTH-bit word, counts STEP bits per clock, returns the count.
// Optional abort input enabled by defining POPCOUNT_SEQ_ABORT_EN.
module popcount_seq #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  localparam int CW   = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef POPCOUNT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             busy
);

  localparam int BEATS = WIDTH / STEP;
  localparam int BW    = $clog2(BEATS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  if (WIDTH < 1) begin : g_bad_width
    $error("popcount_seq: WIDTH must be >= 1");
  end
  if (STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_step
    $error("popcount_seq: STEP must divide WIDTH exactly");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [BW-1:0]    beats_q, beats_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    pc, sum;

  always_comb begin
    pc = '0;
    for (int i = 0; i < STEP; i++) pc = pc + CW'(shift_q[i]);
    sum = acc_q + pc;

    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        shift_d = in_data;
        acc_d   = '0;
        beats_d = BW'(BEATS);
        state_d = S_COUNT;
      end
      S_COUNT: begin
        acc_d   = sum;
        shift_d = shift_q >> STEP;
        beats_d = beats_q - BW'(1);
        if (beats_q == BW'(1)) begin
          cnt_d   = sum;
          state_d = S_DONE;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef POPCOUNT_SEQ_ABORT_EN
    // Abort drops the in-flight word but leaves the last delivered count visible.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      acc_d   = '0;
      beats_d = '0;
      cnt_d   = cnt_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      beats_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_count = cnt_q;

endmodule

// File: tb/tb_popcount_seq.sv
// Scoreboard bench for popcount_seq: an 8/1 and a 16/4 instance, each with its own
// driver, expected-result queue and monitor.
module tb_popcount_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int W  = (g == 0) ? 8 : 16;
    localparam int S  = (g == 0) ? 1 : 4;
    localparam int N  = W / S;
    localparam int CW = $clog2(W + 1);

    typedef struct { int cnt; int k; } exp_t;

    logic          rst_n     = 1'b1;
    logic          in_valid  = 1'b0;
    logic [W-1:0]  in_data   = '0;
    logic          out_ready = 1'b1;
    logic          in_ready, out_valid, busy;
    logic [CW-1:0] out_count;
`ifdef POPCOUNT_SEQ_ABORT_EN
    logic          abort = 1'b0;
`endif

    exp_t q[$];
    int   cyc     = 0;
    int   mode    = 0;  // 0: sink always ready, 1: random, 2: stalled
    bit   prev_v  = 0;
    bit   hs_prev = 0;
    bit   done    = 0;

    popcount_seq #(.WIDTH(W), .STEP(S)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef POPCOUNT_SEQ_ABORT_EN
      .abort    (abort),
`endif
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_count(out_count),
      .busy     (busy)
    );

    function automatic int model(input logic [W-1:0] d);
      int c = 0;
      for (int i = 0; i < W; i++) if (d[i]) c++;
      return c;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
      #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end

    always @(negedge clk) begin
      if (rst_n === 1'b1) begin
        if (hs_prev) check("idle_after_handshake", {in_ready, out_valid, busy}, 3'b100);
        hs_prev = 0;
        if (out_valid) begin
          if (q.size() == 0) check("unexpected_out_valid", out_valid, 0);
          else begin
            if (!prev_v) check("latency", cyc - q[0].k, N);
            check("out_count", out_count, q[0].cnt);
            check("done_flags", {in_ready, busy}, 2'b01);
            if (out_ready) begin
              void'(q.pop_front());
              hs_prev = 1;
            end
          end
        end else if (q.size() != 0) check("count_flags", {in_ready, busy}, 2'b01);
        else check("idle_flags", {in_ready, busy}, 2'b10);
        prev_v = out_valid;
      end
    end

    task automatic send(input logic [W-1:0] d);
      int   t = 0;
      int   k;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      while (in_ready !== 1'b1 && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (in_ready !== 1'b1) begin
        check("accept_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      k = cyc + 1;
      @(posedge clk);
      e.cnt = model(d);
      e.k   = k;
      q.push_back(e);
      #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
    endtask

    task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (q.size() != 0) begin
        check("drain_timeout", q.size(), 0);
        q.delete();
      end
      @(negedge clk);
    endtask

    task automatic reset_seq();
      #1 rst_n = 1'b0;
      #1;
      check("rst_flags", {in_ready, out_valid, busy}, 3'b100);
      check("rst_count", out_count, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    endtask

    if (g == 0) begin : d8
      initial begin
        int t;
        reset_seq();
        send(8'hA5);
        drain();
        send(8'h00);
        send(8'hFF);
        drain();
        // Sink stalls: result must sit unchanged for several cycles.
        mode = 2;
        send(8'h0B);
        t = 0;
        while (out_valid !== 1'b1 && t < 50) begin
          @(negedge clk);
          t++;
        end
        check("stall_valid", out_valid, 1);
        repeat (5) @(negedge clk);
        check("stall_hold", out_count, 3);
        mode = 0;
        drain();
        // Asynchronous reset in the middle of COUNT.
        send(8'hFF);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_flags", {in_ready, out_valid, busy}, 3'b100);
        check("midrst_count", out_count, 0);
        q.delete();
        prev_v  = 0;
        hs_prev = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
`ifdef POPCOUNT_SEQ_ABORT_EN
        send(8'hFF);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        q.delete();
        @(negedge clk);
        check("abort_idle", {in_ready, out_valid, busy}, 3'b100);
        repeat (10) @(negedge clk);
        send(8'h01);
        drain();
`endif
        mode = 1;
        repeat (25) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(W'($urandom));
        end
        send(8'hFF);
        drain();
        done = 1;
      end
    end else begin : d16
      initial begin
        reset_seq();
        send(16'hFFFF);
        send(16'h8001);
        drain();
        mode = 1;
        repeat (15) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(W'($urandom));
        end
        send(16'h0000);
        drain();
        done = 1;
      end
    end
  end

  initial begin
    int t = 0;
    while (!(gi[0].done && gi[1].done) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!(gi[0].done && gi[1].done)) check("global_timeout", 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
